data_memory: RTL and testbench

Multi-cycle data memory for the RV32IM pipeline, sitting directly downstream of the CPU's MEM stage and consuming its load/store requests. It implements byte, halfword and word accesses selected by the instruction's funct3. It holds the pipeline with a BUSYWAIT handshake for a fixed access latency. It is instantiated beside `cpu` in the CPU test bench and in the top level.

---
 rtl/data_memory_pkg.sv | 19 +
 rtl/dmem_align.sv | 55 +++++
 rtl/data_memory.sv | 130 +++++++++++++
 tb/tb_data_memory.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared encodings for the data memory block
package data_memory_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    // Holds LATENCY-1 for the legal range 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - byte-lane steering, load extension and misalignment detect
module dmem_align
    import data_memory_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic       is_byte;
    logic       is_half;
    logic [1:0] off;
    logic [4:0] sh;
    logic [31:0] lane;

    always_comb begin
        is_byte = (func3 == F3_B) || (func3 == F3_BU);
        is_half = (func3 == F3_H) || (func3 == F3_HU);

        misaligned = is_half ? addr_lo[0] : (!is_byte && (addr_lo != 2'b00));

        // Halfwords snap to ADDRESS[1]; words (and undefined codes) snap to lane 0.
        if (is_byte)
            off = addr_lo;
        else if (is_half)
            off = {addr_lo[1], 1'b0};
        else
            off = 2'b00;

        sh       = {off, 3'b000};
        lane     = rword >> sh;
        wdata_sh = wdata << sh;

        if (is_byte)
            wstrb = 4'b0001 << off;
        else if (is_half)
            wstrb = 4'b0011 << off;
        else
            wstrb = 4'b1111;

        case (func3)
            F3_B:    rdata_ext = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   rdata_ext = {24'd0, lane[7:0]};
            F3_H:    rdata_ext = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   rdata_ext = {16'd0, lane[15:0]};
            default: rdata_ext = lane;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - multi-cycle RV32 data memory with BUSYWAIT; DMEM_MISALIGN_TRAP_EN adds MISALIGNED
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT
`ifdef DMEM_MISALIGN_TRAP_EN
   ,output logic        MISALIGNED
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic [2:0]         f3_q;
    logic [IDX_W+1:0]   addr_q;
    logic [31:0]        wdata_q;
    logic               mis_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic [31:0]        rword;
    logic [3:0]         wstrb;
    logic [31:0]        wdata_sh;
    logic [31:0]        rdata_ext;
    logic               mis;
    logic               trap;
    logic               do_access;

    assign rword     = mem[addr_q[IDX_W+1:2]];
    assign do_access = (state == ST_ACCESS) && (cnt == '0);

    dmem_align u_align (
        .func3      (f3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rword      (rword),
        .wstrb      (wstrb),
        .wdata_sh   (wdata_sh),
        .rdata_ext  (rdata_ext),
        .misaligned (mis)
    );

    logic unused_addr;
    assign unused_addr = ^ADDRESS[31:IDX_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap       = mis;
    assign MISALIGNED = mis_q;
`else
    logic unused_mis;
    assign trap       = 1'b0;
    assign unused_mis = mis ^ mis_q;
`endif

    always_comb begin
        case (state)
            ST_IDLE:   BUSYWAIT = READ | WRITE;
            ST_ACCESS: BUSYWAIT = 1'b1;
            default:   BUSYWAIT = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_wr    <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            mis_q    <= 1'b0;
            READDATA <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (READ || WRITE) begin
                        // READ and WRITE together resolve to a store.
                        op_wr   <= WRITE;
                        f3_q    <= FUNC3;
                        addr_q  <= ADDRESS[IDX_W+1:0];
                        wdata_q <= WRITEDATA;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        state <= ST_ACK;
                        mis_q <= trap;
                        if (trap || op_wr)
                            READDATA <= 32'd0;
                        else
                            READDATA <= rdata_ext;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    mis_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gated by RESET so an access abandoned by reset never lands in the array.
    always_ff @(posedge CLK) begin
        if (RESET && do_access && op_wr && !trap) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i])
                    mem[addr_q[IDX_W+1:2]][i*8 +: 8] <= wdata_sh[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory
module tb_data_memory;

    localparam int LAT = 4;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;
    localparam logic [2:0] UD = 3'b011;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [2:0]  FUNC3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        MISALIGNED;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;

    typedef struct {
        logic        chk;
        logic [31:0] rd;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    data_memory #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .READ      (READ),
        .WRITE     (WRITE),
        .FUNC3     (FUNC3),
        .ADDRESS   (ADDRESS),
        .WRITEDATA (WRITEDATA),
        .READDATA  (READDATA),
        .BUSYWAIT  (BUSYWAIT)
`ifdef DMEM_MISALIGN_TRAP_EN
       ,.MISALIGNED (MISALIGNED)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: an ACK is a sampled cycle where a request is held but BUSYWAIT is low.
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET) begin
            busy_cnt = 0;
        end else if (READ || WRITE) begin
            if (BUSYWAIT) begin
                busy_cnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
                end else begin
                    e = exp_q.pop_front();
                    check32("stall_len", 32'(busy_cnt), 32'(LAT + 1));
                    if (e.chk)
                        check32("readdata", READDATA, e.rd);
`ifdef DMEM_MISALIGN_TRAP_EN
                    check32("misaligned", {31'd0, MISALIGNED}, {31'd0, e.mis});
`endif
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (BUSYWAIT && n < 50);
        if (BUSYWAIT) begin
            checks++;
            failures++;
            $display("FAIL timeout: BUSYWAIT still high after %0d cycles, expected low", n);
        end
        @(posedge CLK); #1;
        READ  = 1'b0;
        WRITE = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic chk, input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        e.chk = chk;
        e.rd  = exp_rd;
        e.mis = exp_mis;
        exp_q.push_back(e);
        READ      = rd;
        WRITE     = wr;
        FUNC3     = f3;
        ADDRESS   = a;
        WRITEDATA = wd;
        wait_done();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        RESET     = 1'b0;
        READ      = 1'b1;
        WRITE     = 1'b0;
        FUNC3     = W;
        ADDRESS   = 32'h10;
        WRITEDATA = 32'd0;

        // Reset held for two edges with READ pending; data is uninitialised so only timing is scored.
        e.chk = 1'b0; e.rd = 32'd0; e.mis = 1'b0;
        exp_q.push_back(e);
        @(posedge CLK); #1;
        @(negedge CLK);
        check32("rst_busy", {31'd0, BUSYWAIT}, 32'd1);
        check32("rst_readdata", READDATA, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check32("post_rst_busy", {31'd0, BUSYWAIT}, 32'd1);
        check32("post_rst_readdata", READDATA, 32'd0);
        wait_done();

        access(0, 1, W,  32'h10, 32'hDEADBEEF, 0, 32'd0,        0);
        access(1, 0, W,  32'h10, 32'd0,        1, 32'hDEADBEEF, 0);
        access(0, 1, B,  32'h11, 32'h12345680, 0, 32'd0,        0);
        access(1, 0, W,  32'h10, 32'd0,        1, 32'hDEAD80EF, 0);
        access(1, 0, B,  32'h11, 32'd0,        1, 32'hFFFFFF80, 0);
        access(1, 0, BU, 32'h11, 32'd0,        1, 32'h00000080, 0);
        access(0, 1, H,  32'h12, 32'hABCD1234, 0, 32'd0,        0);
        access(1, 0, W,  32'h10, 32'd0,        1, 32'h123480EF, 0);
        access(1, 0, HU, 32'h12, 32'd0,        1, 32'h00001234, 0);
        access(1, 0, H,  32'h12, 32'd0,        1, 32'h00001234, 0);
        access(1, 0, H,  32'h10, 32'd0,        1, 32'hFFFF80EF, 0);
        access(1, 0, B,  32'h10, 32'd0,        1, 32'hFFFFFFEF, 0);
        access(1, 0, BU, 32'h13, 32'd0,        1, 32'h00000012, 0);
        access(1, 0, UD, 32'h10, 32'd0,        1, 32'h123480EF, 0);
        access(1, 0, W,  32'h410, 32'd0,       1, 32'h123480EF, 0);
        access(1, 0, W,  32'h80000010, 32'd0,  1, 32'h123480EF, 0);

        // Store abandoned by a reset in its second ACCESS cycle.
        access(0, 1, W,  32'h20, 32'hCAFEF00D, 0, 32'd0,        0);
        WRITE = 1'b1; FUNC3 = W; ADDRESS = 32'h20; WRITEDATA = 32'h55;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        WRITE = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check32("abort_idle_busy", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        access(1, 0, W,  32'h20, 32'd0,        1, 32'hCAFEF00D, 0);

        // READ and WRITE together act as a store with READDATA forced to zero.
        access(1, 1, W,  32'h30, 32'h11112222, 1, 32'd0,        0);
        access(1, 0, W,  32'h30, 32'd0,        1, 32'h11112222, 0);

        access(1, 0, W,  32'h13, 32'd0, 1, TRAP ? 32'd0 : 32'h123480EF, TRAP);
        access(1, 0, H,  32'h13, 32'd0, 1, TRAP ? 32'd0 : 32'h00001234, TRAP);
        access(1, 0, W,  32'h10, 32'd0, 1, 32'h123480EF, 0);

        repeat (3) @(posedge CLK);
        check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
